nibble_bank_loader: RTL and testbench
=====================================

Name: nibble_bank_loader

Overview:
- Driver side of the 3-entry nibble bank's load/increment interface.
- Accepts a packed word of NUM_ENTRIES nibbles plus a per-entry skip mask through a start/busy handshake.
- For each entry it either presents the nibble on data_out with ld held high long enough to pass the bank's ld debouncer, or issues a single-cycle inc pulse to advance the bank pointer without writing.
- Sits between the control/test sequencer and the bank. Signals completion with a one-cycle done pulse.

Parameters:
- NUM_ENTRIES, 3, number of nibbles per transfer; must match the bank depth.
- DATA_W, 4, width of each entry.
- HOLD_CYCLES, 8, cycles ld is held high per loaded entry; must be >= the debouncer settle time, and >= 1.
- GAP_CYCLES, 4, idle cycles with ld=0 and inc=0 after every entry; must be >= 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request; sampled only in IDLE.
- word  in  NUM_ENTRIES*DATA_W  packed entries; entry k = word[k*DATA_W +: DATA_W].
- skip_mask  in  NUM_ENTRIES  bit k=1: entry k gets an inc pulse instead of a load.
- busy  out  1  high from the cycle after start is accepted through the done cycle inclusive.
- done  out  1  one-cycle completion pulse.
- ld  out  1  load strobe to the bank, level held HOLD_CYCLES.
- inc  out  1  advance strobe to the bank, single cycle.
- data_out  out  DATA_W  nibble presented to the bank's data_in.

Behaviour:
Registers and reset
- All outputs are registered.
- Reset (asynchronous, any time, including mid-transfer): state=IDLE, busy=0, done=0, ld=0, inc=0, data_out=0, idx=0, timer=0.
- The captured word and mask registers are cleared on reset.

States
- IDLE: outputs low.
  - On start=1 in cycle T: capture word and skip_mask into internal registers, set idx=0, go to ENTRY.
  - word and skip_mask may change freely after cycle T.
- ENTRY (one cycle per entry, at T+1 for entry 0): data_out := captured entry[idx].
  - If mask[idx]=0: ld=1, timer=HOLD_CYCLES-1, go to HOLD.
  - If mask[idx]=1: inc=1 this cycle only, timer=GAP_CYCLES-1, go to GAP.
  - In both cases data_out is updated, even for skipped entries.
  - The ENTRY cycle counts as the first HOLD cycle, or as the inc cycle.
- HOLD: ld stays 1 while timer>0, decrementing each cycle.
  - At timer=0: ld=0, timer=GAP_CYCLES-1, go to GAP.
- GAP: ld=0, inc=0, data_out unchanged; decrement timer.
  - At timer=0: if idx=NUM_ENTRIES-1 go to DONE, else idx+1 and go to ENTRY.
- DONE: done=1, busy=1 for exactly one cycle, then go to IDLE.

Timing and invariants
- Per-entry cost: HOLD_CYCLES+GAP_CYCLES for a loaded entry; 1+GAP_CYCLES for a skipped entry.
- Total latency from the start cycle to the done cycle: 1 + sum of per-entry costs.
- data_out is stable for the whole ld-high window and the following gap, so the bank's debounced edge always sees valid data.
- ld and inc are never high in the same cycle.
- ld is always low for at least GAP_CYCLES between entries.

Boundary conditions
- start while busy=1, including the DONE cycle: ignored, no queuing.
- start and reset together: reset wins.
- Entry order is always 0..NUM_ENTRIES-1; idx never wraps inside a transfer.
- skip_mask all ones: no ld pulses, NUM_ENTRIES inc pulses.
- All counter widths are $clog2 of the largest value held, minimum 1.

Decomposition:
- Shared package nibble_loader_pkg:
  - state enum {IDLE, ENTRY, HOLD, GAP, DONE};
  - default constants for HOLD_CYCLES and GAP_CYCLES;
  - a function returning the timer width.
- One natural sub-module: hold_timer, a loadable down-counter with a zero flag, used for both the HOLD and GAP phases.
- The FSM, capture registers and output registers stay in the top module.

Test Plan:
- Defaults; word=12'hA53, mask=3'b000, start at cycle 0 -> ld high cycles 1-8 with data_out=3, 13-20 with data_out=5, 25-32 with data_out=A; ld low 9-12, 21-24, 33-36; done=1 only at cycle 37; busy=1 cycles 1-37.
- mask=3'b111, start at cycle 0 -> inc=1 at cycles 1, 6, 11 only; ld never high; done at cycle 16.
- mask=3'b010, word=12'h7E1 -> ld+data 1 at cycles 1-8, inc at cycle 13 with data_out=E, ld+data 7 at cycles 18-25, done at cycle 30.
- start re-asserted at cycles 5 and 37 of a transfer, and word changed at cycle 2 -> no effect on the current transfer; the next start is accepted only when busy=0 (cycle 38 or later).
- rst_n low at cycle 15 of the first scenario -> ld, inc, done, busy and data_out go to 0 asynchronously; after release the block is idle and a new start runs a full transfer normally.
- Connect to the 3-entry bank model (debounce + edge detect); run scenario 1, then issue 3 inc pulses -> bank reads back 3, 5, A at pointer positions 0, 1, 2.

Source files
------------

// File: rtl/nibble_loader_pkg.sv
// Shared types and sizing helpers for the nibble bank loader.
package nibble_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ENTRY,
    HOLD,
    GAP,
    DONE
  } state_t;

  localparam int DEF_HOLD_CYCLES = 8;
  localparam int DEF_GAP_CYCLES  = 4;

  // Timer must hold values up to max(hold, gap) - 1; never narrower than 1 bit.
  function automatic int timer_width(input int hold_cycles, input int gap_cycles);
    int max_val;
    max_val = ((hold_cycles > gap_cycles) ? hold_cycles : gap_cycles) - 1;
    timer_width = (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

  // Entry index must hold 0..num_entries-1; never narrower than 1 bit.
  function automatic int index_width(input int num_entries);
    index_width = (num_entries <= 2) ? 1 : $clog2(num_entries);
  endfunction

endpackage

// File: rtl/nibble_bank_loader_hold_timer.sv
// Loadable down-counter with a zero flag; times both the ld-high and gap phases.
module hold_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count_reg;

  // Load takes priority over decrement; the count saturates at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (dec && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/nibble_bank_loader.sv
// Walks a captured word entry by entry, either holding ld with the nibble on
// data_out or pulsing inc, with an idle gap after every entry.
module nibble_bank_loader
  import nibble_loader_pkg::*;
#(
  parameter int NUM_ENTRIES = 3,
  parameter int DATA_W      = 4,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int GAP_CYCLES  = DEF_GAP_CYCLES
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [NUM_ENTRIES*DATA_W-1:0] word,
  input  logic [NUM_ENTRIES-1:0]        skip_mask,
  output logic                          busy,
  output logic                          done,
  output logic                          ld,
  output logic                          inc,
  output logic [DATA_W-1:0]             data_out
);

  localparam int TW = timer_width(HOLD_CYCLES, GAP_CYCLES);
  localparam int IW = index_width(NUM_ENTRIES);

  // The ENTRY cycle already drives ld, so the timer covers the remaining
  // HOLD cycles after the first HOLD cycle: HOLD_CYCLES-2 down to 0.
  localparam logic [TW-1:0] HOLD_LOAD = TW'((HOLD_CYCLES > 1) ? HOLD_CYCLES - 2 : 0);
  localparam logic [TW-1:0] GAP_LOAD  = TW'(GAP_CYCLES - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_ENTRIES - 1);

  state_t                        state_reg;
  logic [IW-1:0]                 idx_reg;
  logic [NUM_ENTRIES*DATA_W-1:0] word_reg;
  logic [NUM_ENTRIES-1:0]        mask_reg;
  logic                          busy_reg;
  logic                          done_reg;
  logic                          ld_reg;
  logic                          inc_reg;
  logic [DATA_W-1:0]             data_reg;

  logic          timer_load;
  logic          timer_dec;
  logic [TW-1:0] timer_val;
  logic          timer_zero;

  logic [IW-1:0]     idx_next;
  logic [DATA_W-1:0] nib_next;
  logic              skip_next;
  logic              is_last;
  logic              enter_hold;

  assign idx_next   = idx_reg + 1'b1;
  assign nib_next   = word_reg[idx_next*DATA_W +: DATA_W];
  assign skip_next  = mask_reg[idx_next];
  assign is_last    = (idx_reg == LAST_IDX);
  assign enter_hold = !mask_reg[idx_reg] && (HOLD_CYCLES > 1);

  hold_timer #(
    .W (TW)
  ) u_hold_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .load_val (timer_val),
    .dec      (timer_dec),
    .zero     (timer_zero)
  );

  // Timer control: arm on leaving ENTRY or HOLD, count down inside HOLD and GAP.
  always_comb begin
    timer_load = 1'b0;
    timer_dec  = 1'b0;
    timer_val  = GAP_LOAD;
    case (state_reg)
      ENTRY: begin
        timer_load = 1'b1;
        if (enter_hold) begin
          timer_val = HOLD_LOAD;
        end
      end
      HOLD: begin
        if (timer_zero) begin
          timer_load = 1'b1;
        end else begin
          timer_dec = 1'b1;
        end
      end
      GAP:     timer_dec = 1'b1;
      default: ;
    endcase
  end

  // Sequencer: outputs are registered and set on the edge that enters each phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      word_reg  <= '0;
      mask_reg  <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      ld_reg    <= 1'b0;
      inc_reg   <= 1'b0;
      data_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            word_reg  <= word;
            mask_reg  <= skip_mask;
            idx_reg   <= '0;
            busy_reg  <= 1'b1;
            data_reg  <= word[DATA_W-1:0];
            ld_reg    <= ~skip_mask[0];
            inc_reg   <= skip_mask[0];
            state_reg <= ENTRY;
          end
        end
        ENTRY: begin
          inc_reg <= 1'b0;
          if (enter_hold) begin
            state_reg <= HOLD;
          end else begin
            ld_reg    <= 1'b0;
            state_reg <= GAP;
          end
        end
        HOLD: begin
          if (timer_zero) begin
            ld_reg    <= 1'b0;
            state_reg <= GAP;
          end
        end
        GAP: begin
          if (timer_zero) begin
            if (is_last) begin
              done_reg  <= 1'b1;
              state_reg <= DONE;
            end else begin
              idx_reg   <= idx_next;
              data_reg  <= nib_next;
              ld_reg    <= ~skip_next;
              inc_reg   <= skip_next;
              state_reg <= ENTRY;
            end
          end
        end
        DONE: begin
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          data_reg  <= '0;
          idx_reg   <= '0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy     = busy_reg;
  assign done     = done_reg;
  assign ld       = ld_reg;
  assign inc      = inc_reg;
  assign data_out = data_reg;

endmodule

// File: tb/tb_nibble_bank_loader.sv
// Self-checking bench for nibble_bank_loader: per-cycle comparison against a
// behavioural timeline model, plus a debounced 3-entry bank model.
module tb_nibble_bank_loader;

  localparam int N      = 3;
  localparam int DW     = 4;
  localparam int HOLD   = 8;
  localparam int GAP    = 4;
  localparam int SETTLE = 3;
  localparam int MAXC   = 64;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic [N*DW-1:0] word;
  logic [N-1:0]    skip_mask;
  logic            busy;
  logic            done;
  logic            ld;
  logic            inc;
  logic [DW-1:0]   data_out;

  int vectors     = 0;
  int miscompares = 0;

  // Expected timeline, indexed by cycles after the start cycle (start = cycle 0).
  logic          exp_ld   [MAXC];
  logic          exp_inc  [MAXC];
  logic          exp_done [MAXC];
  logic          exp_busy [MAXC];
  logic [DW-1:0] exp_data [MAXC];
  int            exp_len;

  nibble_bank_loader #(
    .NUM_ENTRIES (N),
    .DATA_W      (DW),
    .HOLD_CYCLES (HOLD),
    .GAP_CYCLES  (GAP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .word      (word),
    .skip_mask (skip_mask),
    .busy      (busy),
    .done      (done),
    .ld        (ld),
    .inc       (inc),
    .data_out  (data_out)
  );

  always #5 clk = ~clk;

  // Bank model: ld debounced over SETTLE cycles, write on debounced rising
  // edge, pointer advances on each write and on each inc pulse.
  logic [DW-1:0] bank_mem [N];
  int            bank_ptr;
  logic          ld_db;
  logic          ld_db_q;
  int            db_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) bank_mem[i] <= '0;
      bank_ptr <= 0;
      ld_db    <= 1'b0;
      ld_db_q  <= 1'b0;
      db_cnt   <= 0;
    end else begin
      if (ld != ld_db) begin
        if (db_cnt == SETTLE - 1) begin
          ld_db  <= ld;
          db_cnt <= 0;
        end else begin
          db_cnt <= db_cnt + 1;
        end
      end else begin
        db_cnt <= 0;
      end
      ld_db_q <= ld_db;
      if (ld_db && !ld_db_q) begin
        bank_mem[bank_ptr] <= data_out;
        bank_ptr <= (bank_ptr == N - 1) ? 0 : bank_ptr + 1;
      end else if (inc) begin
        bank_ptr <= (bank_ptr == N - 1) ? 0 : bank_ptr + 1;
      end
    end
  end

  // Build the expected waveform straight from the per-entry cost rules.
  task automatic build_model(input logic [N*DW-1:0] w, input logic [N-1:0] m);
    int c;
    logic [DW-1:0] nib;
    for (int i = 0; i < MAXC; i++) begin
      exp_ld[i] = 0; exp_inc[i] = 0; exp_done[i] = 0; exp_busy[i] = 0; exp_data[i] = '0;
    end
    c = 1;
    for (int k = 0; k < N; k++) begin
      nib = w[k*DW +: DW];
      if (!m[k]) begin
        for (int h = 0; h < HOLD; h++) begin
          exp_ld[c] = 1; exp_data[c] = nib; c++;
        end
      end else begin
        exp_inc[c] = 1; exp_data[c] = nib; c++;
      end
      for (int g = 0; g < GAP; g++) begin
        exp_data[c] = nib; c++;
      end
    end
    exp_done[c] = 1;
    exp_len = c;
    for (int i = 1; i <= c; i++) exp_busy[i] = 1;
  endtask

  // Present a request for exactly one sampling edge, then scramble the inputs.
  task automatic kick(input logic [N*DW-1:0] w, input logic [N-1:0] m);
    @(negedge clk);
    word = w; skip_mask = m; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    word = N*DW'($urandom);
    skip_mask = N'($urandom);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; word = '0; skip_mask = '0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({busy, done, ld, inc, data_out} !== {4'b0000, 4'h0}) begin
      miscompares++;
      $display("FAIL reset_held got busy/done/ld/inc=%b%b%b%b data=%h want 0000 data=0",
               busy, done, ld, inc, data_out);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({busy, done, ld, inc, data_out} !== {4'b0000, 4'h0}) begin
      miscompares++;
      $display("FAIL reset_release got busy/done/ld/inc=%b%b%b%b data=%h want 0000 data=0",
               busy, done, ld, inc, data_out);
    end
    $display("test_reset done");
  endtask

  task automatic test_load_all;
    build_model(12'hA53, 3'b000);
    kick(12'hA53, 3'b000);
    for (int c = 1; c <= exp_len + 1; c++) begin
      @(negedge clk);
      vectors++;
      if ({ld, inc, done, busy} !== {exp_ld[c], exp_inc[c], exp_done[c], exp_busy[c]}) begin
        miscompares++;
        $display("FAIL load_all_ctl cyc=%0d got ld/inc/done/busy=%b%b%b%b want %b%b%b%b",
                 c, ld, inc, done, busy, exp_ld[c], exp_inc[c], exp_done[c], exp_busy[c]);
      end
      if (c < exp_len) begin
        vectors++;
        if (data_out !== exp_data[c]) begin
          miscompares++;
          $display("FAIL load_all_data cyc=%0d got %h want %h", c, data_out, exp_data[c]);
        end
      end
    end
    $display("test_load_all word=A53 mask=000 len=%0d", exp_len);
  endtask

  task automatic test_skip_all;
    build_model(12'h9C4, 3'b111);
    kick(12'h9C4, 3'b111);
    for (int c = 1; c <= exp_len + 1; c++) begin
      @(negedge clk);
      vectors++;
      if ({ld, inc, done, busy} !== {exp_ld[c], exp_inc[c], exp_done[c], exp_busy[c]}) begin
        miscompares++;
        $display("FAIL skip_all_ctl cyc=%0d got ld/inc/done/busy=%b%b%b%b want %b%b%b%b",
                 c, ld, inc, done, busy, exp_ld[c], exp_inc[c], exp_done[c], exp_busy[c]);
      end
      if (c < exp_len) begin
        vectors++;
        if (data_out !== exp_data[c]) begin
          miscompares++;
          $display("FAIL skip_all_data cyc=%0d got %h want %h", c, data_out, exp_data[c]);
        end
      end
    end
    $display("test_skip_all word=9C4 mask=111 len=%0d", exp_len);
  endtask

  task automatic test_mixed;
    build_model(12'h7E1, 3'b010);
    kick(12'h7E1, 3'b010);
    for (int c = 1; c <= exp_len + 1; c++) begin
      @(negedge clk);
      vectors++;
      if ({ld, inc, done, busy} !== {exp_ld[c], exp_inc[c], exp_done[c], exp_busy[c]}) begin
        miscompares++;
        $display("FAIL mixed_ctl cyc=%0d got ld/inc/done/busy=%b%b%b%b want %b%b%b%b",
                 c, ld, inc, done, busy, exp_ld[c], exp_inc[c], exp_done[c], exp_busy[c]);
      end
      if (c < exp_len) begin
        vectors++;
        if (data_out !== exp_data[c]) begin
          miscompares++;
          $display("FAIL mixed_data cyc=%0d got %h want %h", c, data_out, exp_data[c]);
        end
      end
    end
    $display("test_mixed word=7E1 mask=010 len=%0d", exp_len);
  endtask

  task automatic test_random;
    logic [N*DW-1:0] w;
    logic [N-1:0]    m;
    for (int t = 0; t < 6; t++) begin
      w = N*DW'($urandom);
      m = N'($urandom_range(0, 7));
      build_model(w, m);
      kick(w, m);
      for (int c = 1; c <= exp_len + 1; c++) begin
        @(negedge clk);
        vectors++;
        if ({ld, inc, done, busy} !== {exp_ld[c], exp_inc[c], exp_done[c], exp_busy[c]}) begin
          miscompares++;
          $display("FAIL random_ctl t=%0d cyc=%0d got ld/inc/done/busy=%b%b%b%b want %b%b%b%b",
                   t, c, ld, inc, done, busy, exp_ld[c], exp_inc[c], exp_done[c], exp_busy[c]);
        end
        if (c < exp_len) begin
          vectors++;
          if (data_out !== exp_data[c]) begin
            miscompares++;
            $display("FAIL random_data t=%0d cyc=%0d got %h want %h", t, c, data_out, exp_data[c]);
          end
        end
      end
      $display("test_random t=%0d word=%h mask=%b len=%0d", t, w, m, exp_len);
    end
  endtask

  // start pulses at cycle 5 and in the done cycle, word changed at cycle 2:
  // none of it may disturb the running transfer or queue a new one.
  task automatic test_start_while_busy;
    build_model(12'hA53, 3'b000);
    kick(12'hA53, 3'b000);
    for (int c = 1; c <= exp_len; c++) begin
      @(negedge clk);
      vectors++;
      if ({ld, inc, done, busy} !== {exp_ld[c], exp_inc[c], exp_done[c], exp_busy[c]}) begin
        miscompares++;
        $display("FAIL busy_ctl cyc=%0d got ld/inc/done/busy=%b%b%b%b want %b%b%b%b",
                 c, ld, inc, done, busy, exp_ld[c], exp_inc[c], exp_done[c], exp_busy[c]);
      end
      if (c < exp_len) begin
        vectors++;
        if (data_out !== exp_data[c]) begin
          miscompares++;
          $display("FAIL busy_data cyc=%0d got %h want %h", c, data_out, exp_data[c]);
        end
      end
      if (c == 2) word = N*DW'($urandom);
      skip_mask = '0;
      start = (c == 5 || c == exp_len) ? 1'b1 : 1'b0;
    end
    for (int c = exp_len + 1; c <= exp_len + 4; c++) begin
      @(negedge clk);
      start = 1'b0;
      vectors++;
      if ({ld, inc, done, busy} !== 4'b0000) begin
        miscompares++;
        $display("FAIL busy_no_queue cyc=%0d got ld/inc/done/busy=%b%b%b%b want 0000",
                 c, ld, inc, done, busy);
      end
    end
    build_model(12'h2B6, 3'b100);
    kick(12'h2B6, 3'b100);
    for (int c = 1; c <= exp_len + 1; c++) begin
      @(negedge clk);
      vectors++;
      if ({ld, inc, done, busy} !== {exp_ld[c], exp_inc[c], exp_done[c], exp_busy[c]}) begin
        miscompares++;
        $display("FAIL busy_next_ctl cyc=%0d got ld/inc/done/busy=%b%b%b%b want %b%b%b%b",
                 c, ld, inc, done, busy, exp_ld[c], exp_inc[c], exp_done[c], exp_busy[c]);
      end
    end
    $display("test_start_while_busy done");
  endtask

  task automatic test_async_reset;
    logic [N*DW-1:0] w;
    logic [N-1:0]    m;
    build_model(12'hA53, 3'b000);
    kick(12'hA53, 3'b000);
    for (int c = 1; c < 15; c++) begin
      @(negedge clk);
      vectors++;
      if ({ld, inc, done, busy} !== {exp_ld[c], exp_inc[c], exp_done[c], exp_busy[c]}) begin
        miscompares++;
        $display("FAIL arst_pre cyc=%0d got ld/inc/done/busy=%b%b%b%b want %b%b%b%b",
                 c, ld, inc, done, busy, exp_ld[c], exp_inc[c], exp_done[c], exp_busy[c]);
      end
    end
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b1;
    word = 12'hFFF;
    #1;
    vectors++;
    if ({busy, done, ld, inc, data_out} !== {4'b0000, 4'h0}) begin
      miscompares++;
      $display("FAIL arst_async got busy/done/ld/inc=%b%b%b%b data=%h want 0000 data=0",
               busy, done, ld, inc, data_out);
    end
    repeat (2) @(negedge clk);
    vectors++;
    if ({busy, done, ld, inc, data_out} !== {4'b0000, 4'h0}) begin
      miscompares++;
      $display("FAIL arst_start_vs_reset got busy/done/ld/inc=%b%b%b%b data=%h want 0000 data=0",
               busy, done, ld, inc, data_out);
    end
    start = 1'b0;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      vectors++;
      if ({busy, done, ld, inc, data_out} !== {4'b0000, 4'h0}) begin
        miscompares++;
        $display("FAIL arst_idle c=%0d got busy/done/ld/inc=%b%b%b%b data=%h want 0000 data=0",
                 c, busy, done, ld, inc, data_out);
      end
    end
    w = N*DW'($urandom);
    m = N'($urandom_range(0, 7));
    build_model(w, m);
    kick(w, m);
    for (int c = 1; c <= exp_len + 1; c++) begin
      @(negedge clk);
      vectors++;
      if ({ld, inc, done, busy} !== {exp_ld[c], exp_inc[c], exp_done[c], exp_busy[c]}) begin
        miscompares++;
        $display("FAIL arst_after_ctl cyc=%0d got ld/inc/done/busy=%b%b%b%b want %b%b%b%b",
                 c, ld, inc, done, busy, exp_ld[c], exp_inc[c], exp_done[c], exp_busy[c]);
      end
      if (c < exp_len) begin
        vectors++;
        if (data_out !== exp_data[c]) begin
          miscompares++;
          $display("FAIL arst_after_data cyc=%0d got %h want %h", c, data_out, exp_data[c]);
        end
      end
    end
    $display("test_async_reset word=%h mask=%b", w, m);
  endtask

  // Load A53 into the bank, then step the pointer with an all-skip transfer and
  // read the bank at each inc pulse.
  task automatic test_bank;
    logic [N*DW-1:0] loaded;
    int              n_inc;
    loaded = 12'hA53;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    build_model(loaded, 3'b000);
    kick(loaded, 3'b000);
    repeat (exp_len + 1) @(negedge clk);
    build_model(12'h000, 3'b111);
    kick(12'h000, 3'b111);
    n_inc = 0;
    for (int c = 1; c <= exp_len + 1; c++) begin
      @(negedge clk);
      if (inc === 1'b1) begin
        vectors++;
        if (bank_ptr != n_inc || bank_mem[bank_ptr] !== loaded[n_inc*DW +: DW]) begin
          miscompares++;
          $display("FAIL bank_readback inc#%0d got ptr=%0d val=%h want ptr=%0d val=%h",
                   n_inc, bank_ptr, bank_mem[bank_ptr], n_inc, loaded[n_inc*DW +: DW]);
        end
        $display("bank inc#%0d ptr=%0d val=%h", n_inc, bank_ptr, bank_mem[bank_ptr]);
        n_inc++;
      end
    end
    vectors++;
    if (n_inc != N) begin
      miscompares++;
      $display("FAIL bank_inc_count got %0d want %0d", n_inc, N);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load_all();
    test_skip_all();
    test_mixed();
    test_random();
    test_start_while_busy();
    test_async_reset();
    test_bank();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
